// File: rtl/mon_dff.sv
// mon_dff: output-side monitor for a single-flop DUT.
//
// Follows the stimulus driver's apply strobe through a LATENCY-deep valid pipe.
// Samples the DUT output on the edge where the result is due, and buffers the
// samples in a first-word-fall-through FIFO that the scenario side drains.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   clear      synchronous flush of pipe, FIFO, counters and sticky flag
//   in_valid   driver strobe: din is applied at this edge
//   dout       DUT output being monitored
//   rd_valid   FIFO head available
//   rd_ready   reader accepts head
//   rd_data    FIFO head value (first-word fall-through)
//   level      current FIFO occupancy
//   sample_cnt samples captured, wraps modulo 2^32
//   drop_cnt   samples dropped on a full FIFO, saturating
//   overflow   sticky, set on the first drop
//   idle       no pending pipe entries and FIFO empty (registered)
module mon_dff #(
   parameter int unsigned WIDTH   = 1,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    in_valid,
   input  logic [WIDTH-1:0]        dout,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [WIDTH-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]  level,
   output logic [31:0]             sample_cnt,
   output logic [15:0]             drop_cnt,
   output logic                    overflow,
   output logic                    idle
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [LATENCY-1:0] pipe_q, pipe_d;
   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [AW:0]        wptr_q, wptr_d, rptr_q, rptr_d;
   logic [31:0]        sample_cnt_q, sample_cnt_d;
   logic [15:0]        drop_cnt_q, drop_cnt_d;
   logic               overflow_q, overflow_d;
   logic               idle_q, idle_d;
   logic               tap, empty, full, pop, push, drop;

   always_comb begin
      // Shift towards the tap; stage 0 takes the fresh strobe.
      pipe_d    = pipe_q << 1;
      pipe_d[0] = in_valid;
      tap       = pipe_q[LATENCY-1];

      empty = (wptr_q == rptr_q);
      full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
      pop   = !empty && rd_ready;
      // A pop on a full FIFO frees the slot the concurrent push needs.
      push  = tap && (!full || pop);
      drop  = tap && full && !pop;

      wptr_d = wptr_q + {{AW{1'b0}}, push};
      rptr_d = rptr_q + {{AW{1'b0}}, pop};

      sample_cnt_d = sample_cnt_q + {31'd0, push};
      drop_cnt_d   = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
      overflow_d = overflow_q | drop;

      // Registered from next state so idle describes the state it is shown with.
      idle_d = (pipe_d == '0) && (wptr_d == rptr_d);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_q       <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         sample_cnt_q <= '0;
         drop_cnt_q   <= '0;
         overflow_q   <= 1'b0;
         idle_q       <= 1'b1;
      end else if (clear) begin
         pipe_q       <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         sample_cnt_q <= '0;
         drop_cnt_q   <= '0;
         overflow_q   <= 1'b0;
         idle_q       <= 1'b1;
      end else begin
         pipe_q       <= pipe_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         sample_cnt_q <= sample_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         overflow_q   <= overflow_d;
         idle_q       <= idle_d;
      end
   end

   // Storage needs no reset: rd_data is forced to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem_q[wptr_q[AW-1:0]] <= dout;
      end
   end

   assign rd_valid   = !empty;
   assign rd_data    = empty ? '0 : mem_q[rptr_q[AW-1:0]];
   assign level      = wptr_q - rptr_q;
   assign sample_cnt = sample_cnt_q;
   assign drop_cnt   = drop_cnt_q;
   assign overflow   = overflow_q;
   assign idle       = idle_q;

endmodule

// File: tb/tb_mon_dff.sv
// tb_mon_dff: scoreboard bench for mon_dff. A LATENCY=1 instance watches a DFF;
// a LATENCY=3 instance watches a 3-stage shift register.
module tb_mon_dff;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        din = 1'b0;
   logic        dout;
   logic        rd_valid, rd_ready = 1'b0;
   logic        rd_data;
   logic [4:0]  level;
   logic [31:0] sample_cnt;
   logic [15:0] drop_cnt;
   logic        overflow, idle;

   logic        iv3 = 1'b0, din3 = 1'b0;
   logic [2:0]  sr3;
   logic        rd_valid3, rd_data3, overflow3, idle3;
   logic [4:0]  level3;
   logic [31:0] sample_cnt3;
   logic [15:0] drop_cnt3;

   int   checks = 0;
   int   errors = 0;
   logic exp_q[$];
   logic [19:0] pat;

   always #5 clk = ~clk;

   // DUT stand-ins: a single flop and a 3-stage shift register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout <= 1'b0;
         sr3  <= '0;
      end else begin
         dout <= din;
         sr3  <= {sr3[1:0], din3};
      end
   end

   mon_dff #(.WIDTH(1), .DEPTH(16), .LATENCY(1)) u_dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .dout(dout),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .level(level),
      .sample_cnt(sample_cnt), .drop_cnt(drop_cnt), .overflow(overflow), .idle(idle)
   );

   mon_dff #(.WIDTH(1), .DEPTH(16), .LATENCY(3)) u_dut3 (
      .clk(clk), .rst(rst), .clear(1'b0), .in_valid(iv3), .dout(sr3[2]),
      .rd_valid(rd_valid3), .rd_ready(1'b0), .rd_data(rd_data3), .level(level3),
      .sample_cnt(sample_cnt3), .drop_cnt(drop_cnt3), .overflow(overflow3), .idle(idle3)
   );

   // Monitor: every accepted read is compared against the scoreboard head.
   always @(negedge clk) begin
      if (rst && rd_valid && rd_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_read: got %0b, required no data (scoreboard empty)", rd_data);
         end else begin
            logic e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               errors++;
               $display("FAIL sb_read: got %0b, required %0b", rd_data, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // One clock: drive the strobe and data, optionally record the expected sample.
   task automatic cycle(input logic v, input logic d, input bit exp_push);
      in_valid = v;
      din      = d;
      if (exp_push) exp_q.push_back(d);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      rd_ready = 1'b1;
      for (int i = 0; i < 40 && level != 0; i++) cycle(1'b0, 1'b0, 1'b0);
      rd_ready = 1'b0;
      check(name, {27'd0, level}, 32'd0);
      check({name, "_idle"}, {31'd0, idle}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      pat = 20'b1011_0010_1110_0101_1001;
      #1 rst = 1'b0;
      #1;
      check("rst_level", {27'd0, level}, 0);
      check("rst_rd_valid", {31'd0, rd_valid}, 0);
      check("rst_rd_data", {31'd0, rd_data}, 0);
      check("rst_idle", {31'd0, idle}, 1);
      check("rst_sample_cnt", sample_cnt, 0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Basic capture: 1,0,1,1 held in the FIFO, then drained in order.
      cycle(1, 1, 1); cycle(1, 0, 1); cycle(1, 1, 1); cycle(1, 1, 1);
      cycle(0, 0, 0);
      check("basic_level", {27'd0, level}, 4);
      check("basic_sample_cnt", sample_cnt, 4);
      check("basic_idle", {31'd0, idle}, 0);
      check("basic_head", {31'd0, rd_data}, 1);
      drain("basic_drain");

      // Latency alignment on the 3-stage instance: push lands exactly at edge k+3.
      iv3 = 1'b1; din3 = 1'b1;
      cycle(0, 0, 0);
      iv3 = 1'b0; din3 = 1'b0;
      check("lat3_k", {27'd0, level3}, 0);
      cycle(0, 0, 0);
      check("lat3_k1", {27'd0, level3}, 0);
      cycle(0, 0, 0);
      check("lat3_k2", {27'd0, level3}, 0);
      cycle(0, 0, 0);
      check("lat3_k3_level", {27'd0, level3}, 1);
      check("lat3_k3_data", {31'd0, rd_data3}, 1);
      check("lat3_k3_cnt", sample_cnt3, 1);
      cycle(0, 0, 0);
      check("lat3_k4_level", {27'd0, level3}, 1);

      // Clear restarts the counters.
      clear = 1'b1;
      cycle(0, 0, 0);
      clear = 1'b0;
      check("clear_sample_cnt", sample_cnt, 0);

      // Overflow: 20 strobes into 16 entries, the last 4 dropped.
      for (int i = 0; i < 20; i++) cycle(1, pat[i], i < 16);
      cycle(0, 0, 0);
      check("ovf_level", {27'd0, level}, 16);
      check("ovf_sample_cnt", sample_cnt, 16);
      check("ovf_drop_cnt", {16'd0, drop_cnt}, 4);
      check("ovf_overflow", {31'd0, overflow}, 1);

      // Full with concurrent push/pop: 11 push+pop pairs across the pointer wrap.
      cycle(1, 1, 1);
      rd_ready = 1'b1;
      for (int i = 0; i < 10; i++) cycle(1, pat[i+3], 1);
      cycle(0, 0, 0);
      rd_ready = 1'b0;
      check("full_pp_level", {27'd0, level}, 16);
      check("full_pp_drop_cnt", {16'd0, drop_cnt}, 4);
      check("full_pp_sample_cnt", sample_cnt, 27);
      drain("full_pp_drain");

      // Clear on the edge a push is due: sample discarded, counters and flag reset.
      cycle(1, 1, 0);
      clear = 1'b1;
      cycle(0, 0, 0);
      clear = 1'b0;
      check("clr_push_level", {27'd0, level}, 0);
      check("clr_push_sample_cnt", sample_cnt, 0);
      check("clr_push_overflow", {31'd0, overflow}, 0);
      check("clr_push_drop_cnt", {16'd0, drop_cnt}, 0);
      cycle(0, 0, 0);
      check("clr_push_level_after", {27'd0, level}, 0);

      // Asynchronous reset mid-cycle with 7 entries held.
      for (int i = 0; i < 7; i++) cycle(1, pat[i], 1);
      cycle(0, 0, 0);
      check("arst_pre_level", {27'd0, level}, 7);
      #2 rst = 1'b0;
      #1;
      check("arst_level", {27'd0, level}, 0);
      check("arst_rd_valid", {31'd0, rd_valid}, 0);
      check("arst_rd_data", {31'd0, rd_data}, 0);
      check("arst_idle", {31'd0, idle}, 1);
      check("arst_sample_cnt", sample_cnt, 0);
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b1;
      cycle(1, 1, 1);
      cycle(0, 0, 0);
      check("arst_post_level", {27'd0, level}, 1);
      check("arst_post_sample_cnt", sample_cnt, 1);
      drain("arst_drain");

      check("sb_leftover", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
